// File: rtl/blt_mem_arbiter.sv
// Purpose: arbitrates the shared video/work RAM port between the 6809 CPU and the blitter, including the CPU halt handshake.
// Latency: read READ_LATENCY+2, full write 2, suppressed write 1, nibble RMW READ_LATENCY+3 cycles from request to blt_ack.
// Backpressure: the blitter holds read/write until blt_ack; requests are sampled only in B_IDLE, one at a time.
module blt_mem_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_sync,
    input  logic              cpu_ba,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [7:0]        cpu_data_out,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic              cpu_halt,
    input  logic              halt,
    output logic              halt_ack,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] blt_address,
    input  logic [7:0]        blt_data_out,
    input  logic              en_upper,
    input  logic              en_lower,
    output logic              blt_ack,
    output logic [7:0]        blt_data_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data_out,
    input  logic [7:0]        mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr
);

    typedef enum logic [2:0] {
        CPU_OWN,
        HALT_WAIT,
        B_IDLE,
        B_RD,
        B_RMW,
        B_WR,
        B_ACK
    } state_t;

    // Counter compares against the read latency; 3 bits covers the legal 1..4 range.
    localparam logic [2:0] RD_LAT = 3'(READ_LATENCY);

    state_t            state, state_nxt;
    logic              cpu_halt_nxt, halt_ack_nxt, blt_ack_nxt;
    logic [7:0]        blt_data_in_nxt;
    logic              rd_q, rd_nxt, wr_q, wr_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        wdat_q, wdat_nxt;
    logic              en_up_q, en_up_nxt, en_lo_q, en_lo_nxt;
    logic [2:0]        cnt, cnt_nxt;

    // Register stage: all state and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CPU_OWN;
            cpu_halt    <= 1'b0;
            halt_ack    <= 1'b0;
            blt_ack     <= 1'b0;
            blt_data_in <= 8'h00;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdat_q      <= 8'h00;
            en_up_q     <= 1'b0;
            en_lo_q     <= 1'b0;
            cnt         <= 3'd0;
        end else begin
            state       <= state_nxt;
            cpu_halt    <= cpu_halt_nxt;
            halt_ack    <= halt_ack_nxt;
            blt_ack     <= blt_ack_nxt;
            blt_data_in <= blt_data_in_nxt;
            rd_q        <= rd_nxt;
            wr_q        <= wr_nxt;
            addr_q      <= addr_nxt;
            wdat_q      <= wdat_nxt;
            en_up_q     <= en_up_nxt;
            en_lo_q     <= en_lo_nxt;
            cnt         <= cnt_nxt;
        end
    end

    // Next-state and next-register logic; strobes default low so each is a single-cycle pulse.
    always_comb begin
        state_nxt       = state;
        cpu_halt_nxt    = cpu_halt;
        halt_ack_nxt    = halt_ack;
        blt_data_in_nxt = blt_data_in;
        rd_nxt          = 1'b0;
        wr_nxt          = 1'b0;
        addr_nxt        = addr_q;
        wdat_nxt        = wdat_q;
        en_up_nxt       = en_up_q;
        en_lo_nxt       = en_lo_q;
        cnt_nxt         = cnt;

        case (state)
            CPU_OWN: begin
                if (halt) begin
                    cpu_halt_nxt = 1'b1;
                    state_nxt    = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                // A withdrawn halt wins over a simultaneous bus grant.
                if (!halt) begin
                    cpu_halt_nxt = 1'b0;
                    state_nxt    = CPU_OWN;
                end else if (cpu_ba && e_sync) begin
                    halt_ack_nxt = 1'b1;
                    state_nxt    = B_IDLE;
                end
            end
            B_IDLE: begin
                cnt_nxt = 3'd0;
                if (read) begin
                    addr_nxt  = blt_address;
                    rd_nxt    = 1'b1;
                    state_nxt = B_RD;
                end else if (write) begin
                    addr_nxt  = blt_address;
                    wdat_nxt  = blt_data_out;
                    en_up_nxt = en_upper;
                    en_lo_nxt = en_lower;
                    if (en_upper && en_lower) begin
                        wr_nxt    = 1'b1;
                        state_nxt = B_WR;
                    end else if (!en_upper && !en_lower) begin
                        state_nxt = B_ACK;
                    end else begin
                        rd_nxt    = 1'b1;
                        state_nxt = B_RMW;
                    end
                end else if (!halt) begin
                    halt_ack_nxt = 1'b0;
                    cpu_halt_nxt = 1'b0;
                    state_nxt    = CPU_OWN;
                end
            end
            B_RD: begin
                if (cnt == RD_LAT) begin
                    blt_data_in_nxt = mem_data_in;
                    state_nxt       = B_ACK;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            B_RMW: begin
                if (cnt == RD_LAT) begin
                    wdat_nxt  = en_up_q ? {wdat_q[7:4], mem_data_in[3:0]}
                                        : {mem_data_in[7:4], wdat_q[3:0]};
                    wr_nxt    = 1'b1;
                    state_nxt = B_WR;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            B_WR:    state_nxt = B_ACK;
            B_ACK:   state_nxt = B_IDLE;
            default: state_nxt = CPU_OWN;
        endcase

        // Ack is high exactly for the single cycle spent in B_ACK.
        blt_ack_nxt = (state_nxt == B_ACK);
    end

    // RAM port: CPU passthrough while it owns the bus, otherwise the blitter-side registers.
    always_comb begin
        if (state == CPU_OWN) begin
            mem_address  = cpu_address;
            mem_data_out = cpu_data_out;
            mem_rd       = cpu_rd;
            mem_wr       = cpu_wr;
        end else begin
            mem_address  = addr_q;
            mem_data_out = wdat_q;
            mem_rd       = rd_q;
            mem_wr       = wr_q;
        end
    end

endmodule

// File: tb/tb_blt_mem_arbiter.sv
// Purpose: self-checking bench for blt_mem_arbiter with a RAM model and write/ack scoreboard.
// Latency: RAM model returns read data READ_LATENCY cycles after the mem_rd cycle.
// Backpressure: bench holds blitter requests until blt_ack, then drops them.
module tb_blt_mem_arbiter;

    localparam int RL = 2;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          e_sync, cpu_ba, cpu_rd, cpu_wr, halt, read, write, en_upper, en_lower;
    logic [AW-1:0] cpu_address, blt_address, mem_address;
    logic [7:0]    cpu_data_out, blt_data_out, blt_data_in, mem_data_out, mem_data_in;
    logic          cpu_halt, halt_ack, blt_ack, mem_rd, mem_wr;

    always #5 clk = ~clk;

    blt_mem_arbiter #(.READ_LATENCY(RL), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .e_sync(e_sync), .cpu_ba(cpu_ba),
        .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_halt(cpu_halt),
        .halt(halt), .halt_ack(halt_ack), .read(read), .write(write),
        .blt_address(blt_address), .blt_data_out(blt_data_out),
        .en_upper(en_upper), .en_lower(en_lower), .blt_ack(blt_ack),
        .blt_data_in(blt_data_in), .mem_address(mem_address),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    // RAM model: writes land on the clock edge, reads come back RL cycles after the mem_rd cycle.
    logic [7:0]  ram [0:65535];
    logic [AW:0] rpipe [RL];

    always @(posedge clk) begin
        if (mem_wr) ram[mem_address] <= mem_data_out;
        rpipe[0] <= {mem_rd, mem_address};
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end

    assign mem_data_in = rpipe[RL-1][AW] ? ram[rpipe[RL-1][AW-1:0]] : 8'hEE;

    int            checks = 0;
    int            failures = 0;
    int            n_rd = 0, n_wr = 0, n_ack = 0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [23:0]   exp_wr_q [$];
    logic [7:0]    exp_ack_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every write and every ack must match the head of its scoreboard queue.
    always @(negedge clk) begin
        logic [23:0] ew;
        if (mem_rd) begin
            n_rd++;
            last_rd_addr = mem_address;
        end
        if (mem_wr) begin
            n_wr++;
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_wr", 32'(exp_wr_q.size()), 32'd1);
            end else begin
                ew = exp_wr_q.pop_front();
                chk("wr_addr", 32'(mem_address), 32'(ew[23:8]));
                chk("wr_data", 32'(mem_data_out), 32'(ew[7:0]));
            end
        end
        if (blt_ack) begin
            n_ack++;
            if (exp_ack_q.size() == 0) chk("unexpected_ack", 32'(exp_ack_q.size()), 32'd1);
            else chk("ack_data", 32'(blt_data_in), 32'(exp_ack_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one blitter request, wait (bounded) for blt_ack, check latency, report strobe deltas.
    task automatic blt_req(input string tag, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [7:0] d,
                           input logic eu, input logic el, input int exp_lat,
                           input bit scramble, output int drd, output int dwr);
        int  rd0, wr0, lat;
        bit  seen;
        rd0 = n_rd;
        wr0 = n_wr;
        read = rd; write = wr; blt_address = a; blt_data_out = d;
        en_upper = eu; en_lower = el;
        seen = 0;
        lat = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (blt_ack) begin
                seen = 1;
                lat = k;
            end else if (scramble && k == 1) begin
                blt_data_out = ~d; en_upper = ~eu; en_lower = ~el;
                blt_address = a ^ 16'hFFFF;
            end
        end
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        read = 0; write = 0;
        drd = n_rd - rd0;
        dwr = n_wr - wr0;
    endtask

    initial begin
        int drd, dwr, w0, a0;
        reset = 1; e_sync = 0; cpu_ba = 0; cpu_rd = 0; cpu_wr = 0; halt = 0;
        read = 0; write = 0; en_upper = 0; en_lower = 0;
        cpu_address = '0; blt_address = '0; cpu_data_out = 0; blt_data_out = 0;
        step(3);
        chk("rst_cpu_halt", 32'(cpu_halt), 0);
        chk("rst_halt_ack", 32'(halt_ack), 0);
        chk("rst_blt_ack", 32'(blt_ack), 0);
        chk("rst_blt_data_in", 32'(blt_data_in), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        reset = 0;
        step(1);

        // CPU passthrough writes, also used to preload the RAM.
        cpu_address = 16'h1234; cpu_data_out = 8'hA5; cpu_wr = 1;
        exp_wr_q.push_back({16'h1234, 8'hA5});
        #1;
        chk("pass_addr", 32'(mem_address), 32'h1234);
        chk("pass_wr", 32'(mem_wr), 1);
        step(1);
        cpu_address = 16'h0200; cpu_data_out = 8'h5A;
        exp_wr_q.push_back({16'h0200, 8'h5A});
        step(1);
        cpu_wr = 0;
        step(1);

        // Halt handshake: cpu_ba 3 cycles in, e_sync on the 5th; held cpu_wr must not reach RAM.
        w0 = n_wr;
        halt = 1;
        step(1);
        chk("hs_cpu_halt", 32'(cpu_halt), 1);
        cpu_address = 16'h0300; cpu_data_out = 8'h99; cpu_wr = 1;
        step(2);
        cpu_ba = 1;
        chk("hs_no_ack_early", 32'(halt_ack), 0);
        step(2);
        e_sync = 1;
        chk("hs_no_ack_before_esync", 32'(halt_ack), 0);
        step(1);
        e_sync = 0;
        chk("hs_ack", 32'(halt_ack), 1);
        cpu_wr = 0;
        chk("hs_cpu_wr_blocked", 32'(n_wr), 32'(w0));

        // Plain read.
        exp_ack_q.push_back(8'hA5);
        blt_req("read", 1, 0, 16'h1234, 8'h00, 0, 0, RL + 2, 0, drd, dwr);
        chk("read_rd_count", 32'(drd), 1);
        chk("read_wr_count", 32'(dwr), 0);
        chk("read_rd_addr", 32'(last_rd_addr), 32'h1234);

        // Full write.
        exp_wr_q.push_back({16'h0100, 8'h3C});
        exp_ack_q.push_back(8'hA5);
        blt_req("fullwr", 0, 1, 16'h0100, 8'h3C, 1, 1, 2, 0, drd, dwr);
        chk("fullwr_rd_count", 32'(drd), 0);
        chk("fullwr_wr_count", 32'(dwr), 1);

        // Upper-nibble RMW.
        exp_wr_q.push_back({16'h0200, 8'hFA});
        exp_ack_q.push_back(8'hA5);
        blt_req("rmw_up", 0, 1, 16'h0200, 8'hF0, 1, 0, RL + 3, 0, drd, dwr);
        chk("rmw_up_rd_count", 32'(drd), 1);
        chk("rmw_up_wr_count", 32'(dwr), 1);
        chk("rmw_up_ram", 32'(ram[16'h0200]), 32'hFA);

        // Restore 0x5A, then lower-nibble RMW with inputs scrambled mid-access.
        exp_wr_q.push_back({16'h0200, 8'h5A});
        exp_ack_q.push_back(8'hA5);
        blt_req("restore", 0, 1, 16'h0200, 8'h5A, 1, 1, 2, 0, drd, dwr);
        exp_wr_q.push_back({16'h0200, 8'h5F});
        exp_ack_q.push_back(8'hA5);
        blt_req("rmw_lo", 0, 1, 16'h0200, 8'h0F, 0, 1, RL + 3, 1, drd, dwr);
        chk("rmw_lo_rd_count", 32'(drd), 1);
        chk("rmw_lo_ram", 32'(ram[16'h0200]), 32'h5F);

        // Both enables off: ack only.
        exp_ack_q.push_back(8'hA5);
        blt_req("nowr", 0, 1, 16'h0200, 8'h12, 0, 0, 1, 0, drd, dwr);
        chk("nowr_rd_count", 32'(drd), 0);
        chk("nowr_wr_count", 32'(dwr), 0);
        chk("nowr_ram", 32'(ram[16'h0200]), 32'h5F);

        // Read wins over a simultaneous write.
        exp_ack_q.push_back(8'h3C);
        blt_req("prio", 1, 1, 16'h0100, 8'h77, 1, 1, RL + 2, 0, drd, dwr);
        chk("prio_rd_count", 32'(drd), 1);
        chk("prio_wr_count", 32'(dwr), 0);

        // Release in B_IDLE; CPU passthrough resumes.
        halt = 0;
        step(1);
        chk("rel_cpu_halt", 32'(cpu_halt), 0);
        chk("rel_halt_ack", 32'(halt_ack), 0);
        cpu_ba = 0;
        cpu_address = 16'h5555; cpu_rd = 1;
        #1;
        chk("rel_pass_rd", 32'(mem_rd), 1);
        chk("rel_pass_addr", 32'(mem_address), 32'h5555);
        step(1);
        cpu_rd = 0;

        // Halt withdrawn before the CPU grants the bus.
        halt = 1;
        step(1);
        chk("abort_cpu_halt_set", 32'(cpu_halt), 1);
        step(1);
        halt = 0;
        step(1);
        chk("abort_cpu_halt_clr", 32'(cpu_halt), 0);
        chk("abort_no_ack", 32'(halt_ack), 0);

        // Reset during an RMW: no write, no ack, back to CPU ownership.
        halt = 1; cpu_ba = 1;
        step(1);
        e_sync = 1;
        step(1);
        e_sync = 0;
        chk("rst2_halt_ack", 32'(halt_ack), 1);
        w0 = n_wr;
        a0 = n_ack;
        write = 1; blt_address = 16'h0200; blt_data_out = 8'hF0; en_upper = 1; en_lower = 0;
        step(2);
        reset = 1;
        step(1);
        reset = 0; write = 0; halt = 0; cpu_ba = 0;
        cpu_address = 16'h0ABC;
        step(8);
        chk("rst2_no_wr", 32'(n_wr), 32'(w0));
        chk("rst2_no_ack", 32'(n_ack), 32'(a0));
        chk("rst2_cpu_halt", 32'(cpu_halt), 0);
        chk("rst2_halt_ack_clr", 32'(halt_ack), 0);
        chk("rst2_pass_addr", 32'(mem_address), 32'h0ABC);
        chk("rst2_ram", 32'(ram[16'h0200]), 32'h5F);

        chk("wr_queue_empty", 32'(exp_wr_q.size()), 0);
        chk("ack_queue_empty", 32'(exp_ack_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
